// File: rtl/output_comparator_pkg.sv
// Shared defaults for the output comparator block.
// Provides the default sample width, golden depth, signedness and tolerance
// used by output_comparator and its interface.
package comparator_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_IS_SIGNED  = 1;
  localparam int DEF_TOLERANCE  = 0;

  // Address width for a memory of the given depth (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/output_comparator_if.sv
// Bus bundle for the output comparator.
// Carries the golden-memory write port and the sample-under-test stream.
//   master: testbench/producer side, drives every signal
//   slave : comparator side, receives every signal
interface output_comparator_if
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
);

  localparam int AW = addr_width(DEPTH);

  logic                  gold_wr_en;
  logic [AW-1:0]         gold_wr_addr;
  logic [DATA_WIDTH-1:0] gold_wr_data;
  logic                  dut_ready;
  logic [DATA_WIDTH-1:0] dut_output;

  modport master (
    output gold_wr_en, gold_wr_addr, gold_wr_data, dut_ready, dut_output
  );

  modport slave (
    input gold_wr_en, gold_wr_addr, gold_wr_data, dut_ready, dut_output
  );

endinterface

// File: rtl/output_comparator_absdiff.sv
// Purely combinational absolute difference |a - b|.
// Ports:
//   a, b : DATA_WIDTH-bit operands, two's complement when IS_SIGNED=1
//   diff : DATA_WIDTH+1-bit magnitude of the difference
module output_comparator_absdiff
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IS_SIGNED  = DEF_IS_SIGNED
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH:0]   diff
);

  logic [DATA_WIDTH:0] a_ext;
  logic [DATA_WIDTH:0] b_ext;
  logic [DATA_WIDTH:0] raw;

  // Extend to one extra bit so the difference of any two operands fits as a
  // signed value; the magnitude then always fits unsigned in the same width.
  always_comb begin
    a_ext = {1'b0, a};
    b_ext = {1'b0, b};
    if (IS_SIGNED != 0) begin
      a_ext = {a[DATA_WIDTH-1], a};
      b_ext = {b[DATA_WIDTH-1], b};
    end else begin
      a_ext = {1'b0, a};
      b_ext = {1'b0, b};
    end
    raw = a_ext - b_ext;
    if (raw[DATA_WIDTH]) begin
      diff = b_ext - a_ext;
    end else begin
      diff = raw;
    end
  end

endmodule

// File: rtl/output_comparator.sv
// Streams DUT samples against a golden memory and tallies the result.
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous reset, active HIGH despite the name
//   clear          : synchronous restart of the check (golden memory kept)
//   bus            : golden write port and sample stream (slave modport)
//   pass_cnt       : samples within tolerance
//   fail_cnt       : samples outside tolerance
//   done           : DEPTH samples compared
//   all_pass       : done with no fail and no overflow
//   first_fail_vld : a mismatch has been captured
//   first_fail_idx : index of the first mismatch
//   overflow       : a sample arrived after done
module output_comparator
  import comparator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int IS_SIGNED  = DEF_IS_SIGNED,
  parameter int TOLERANCE  = DEF_TOLERANCE,
  localparam int AW = addr_width(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output_comparator_if.slave    bus,
  output logic [CW-1:0]         pass_cnt,
  output logic [CW-1:0]         fail_cnt,
  output logic                  done,
  output logic                  all_pass,
  output logic                  first_fail_vld,
  output logic [AW-1:0]         first_fail_idx,
  output logic                  overflow
);

  localparam logic [DATA_WIDTH:0] TOL_V  = (DATA_WIDTH+1)'(TOLERANCE);
  localparam logic [CW-1:0]       LAST_V = CW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] golden [DEPTH];
  logic [CW-1:0]         idx;
  logic [DATA_WIDTH-1:0] gold_rd;
  logic [DATA_WIDTH:0]   diff;
  logic                  sample_ok;

  // Golden memory write port; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (bus.gold_wr_en) begin
      golden[bus.gold_wr_addr] <= bus.gold_wr_data;
    end
  end

  // Asynchronous read: a same-cycle write lands at the edge, so the compare
  // naturally sees the old value. idx == DEPTH only once done, when the read
  // is unused, so truncating it to the address width is safe.
  assign gold_rd = golden[idx[AW-1:0]];

  output_comparator_absdiff #(
    .DATA_WIDTH (DATA_WIDTH),
    .IS_SIGNED  (IS_SIGNED)
  ) u_absdiff (
    .a    (bus.dut_output),
    .b    (gold_rd),
    .diff (diff)
  );

  assign sample_ok = (diff <= TOL_V);

  // Sample pointer, counters and status flags.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if (clear) begin
      idx            <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
    end else if (bus.dut_ready) begin
      if (done) begin
        overflow <= 1'b1;
      end else begin
        if (sample_ok) begin
          pass_cnt <= pass_cnt + CW'(1);
        end else begin
          fail_cnt <= fail_cnt + CW'(1);
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx[AW-1:0];
          end
        end
        idx <= idx + CW'(1);
        if (idx == LAST_V) begin
          done <= 1'b1;
        end
      end
    end
  end

  assign all_pass = done && (fail_cnt == '0) && !overflow;

endmodule

// File: tb/tb_output_comparator.sv
// Directed testbench for output_comparator.
// Three instances share one bus and stream:
//   u0 : signed,   TOLERANCE 0
//   u1 : signed,   TOLERANCE 1
//   u2 : unsigned, TOLERANCE 1
module tb_output_comparator;

  localparam int DW = 24;
  localparam int DP = 4;

  localparam logic [DW-1:0] V5   = 24'd5;
  localparam logic [DW-1:0] VM3  = 24'hFFFFFD;
  localparam logic [DW-1:0] V100 = 24'd100;
  localparam logic [DW-1:0] V0   = 24'd0;
  localparam logic [DW-1:0] VM2  = 24'hFFFFFE;
  localparam logic [DW-1:0] V6   = 24'd6;
  localparam logic [DW-1:0] VM4  = 24'hFFFFFC;
  localparam logic [DW-1:0] V99  = 24'd99;
  localparam logic [DW-1:0] V1   = 24'd1;
  localparam logic [DW-1:0] VM1  = 24'hFFFFFF;

  logic clk;
  logic rst_n;
  logic clear;

  int checks;
  int errors;

  output_comparator_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  logic [2:0] p0, f0, p1, f1, p2, f2;
  logic       d0, ap0, fv0, ov0, d1, ap1, fv1, ov1, d2, ap2, fv2, ov2;
  logic [1:0] fi0, fi1, fi2;

  output_comparator #(.DATA_WIDTH(DW), .DEPTH(DP), .IS_SIGNED(1), .TOLERANCE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .pass_cnt(p0), .fail_cnt(f0), .done(d0), .all_pass(ap0),
    .first_fail_vld(fv0), .first_fail_idx(fi0), .overflow(ov0)
  );

  output_comparator #(.DATA_WIDTH(DW), .DEPTH(DP), .IS_SIGNED(1), .TOLERANCE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .pass_cnt(p1), .fail_cnt(f1), .done(d1), .all_pass(ap1),
    .first_fail_vld(fv1), .first_fail_idx(fi1), .overflow(ov1)
  );

  output_comparator #(.DATA_WIDTH(DW), .DEPTH(DP), .IS_SIGNED(0), .TOLERANCE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
    .pass_cnt(p2), .fail_cnt(f2), .done(d2), .all_pass(ap2),
    .first_fail_vld(fv2), .first_fail_idx(fi2), .overflow(ov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; inputs change #1 after a rising edge.
  task automatic step(input logic rdy, input logic [DW-1:0] v,
                      input logic wen, input logic [1:0] wa, input logic [DW-1:0] wd);
    bus.dut_ready    = rdy;
    bus.dut_output   = v;
    bus.gold_wr_en   = wen;
    bus.gold_wr_addr = wa;
    bus.gold_wr_data = wd;
    @(posedge clk);
    #1;
    bus.dut_ready  = 1'b0;
    bus.gold_wr_en = 1'b0;
  endtask

  task automatic sample(input logic [DW-1:0] v);
    step(1'b1, v, 1'b0, 2'd0, '0);
  endtask

  task automatic stream4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
    sample(a);
    sample(b);
    sample(c);
    sample(d);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, '0, 1'b0, 2'd0, '0);
    clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    clear = 1'b0;
    bus.dut_ready = 1'b0;
    bus.dut_output = '0;
    bus.gold_wr_en = 1'b0;
    bus.gold_wr_addr = 2'd0;
    bus.gold_wr_data = '0;
    @(posedge clk);
    #1;

    // Golden memory loads while reset is held; it has no reset of its own.
    step(1'b0, '0, 1'b1, 2'd0, V5);
    step(1'b0, '0, 1'b1, 2'd1, VM3);
    step(1'b0, '0, 1'b1, 2'd2, V100);
    step(1'b0, '0, 1'b1, 2'd3, V0);
    check_eq("rst_pass", p0, 0);
    check_eq("rst_done", d0, 0);
    check_eq("rst_allpass", ap0, 0);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 2'd0, '0);

    // Identical stream.
    stream4(V5, VM3, V100, V0);
    check_eq("ident_pass", p0, 4);
    check_eq("ident_fail", f0, 0);
    check_eq("ident_done", d0, 1);
    check_eq("ident_allpass", ap0, 1);
    check_eq("ident_uns_pass", p2, 4);

    // Clear wins over a simultaneous sample.
    clear = 1'b1;
    sample(V5);
    clear = 1'b0;
    check_eq("clr_pass", p0, 0);
    check_eq("clr_done", d0, 0);

    // One mismatch at index 1.
    stream4(V5, VM2, V100, V0);
    check_eq("mis_fail", f0, 1);
    check_eq("mis_ffidx", fi0, 1);
    check_eq("mis_ffvld", fv0, 1);
    check_eq("mis_allpass", ap0, 0);
    check_eq("mis_tol1_pass", p1, 4);

    // All samples off by one.
    do_clear();
    stream4(V6, VM4, V99, V1);
    check_eq("tol1_pass", p1, 4);
    check_eq("tol1_allpass", ap1, 1);
    check_eq("tol0_fail", f0, 4);
    check_eq("tol0_ffidx", fi0, 0);

    // Fifth sample after done.
    do_clear();
    stream4(V5, VM3, V100, V0);
    check_eq("pre_ovf", ov0, 0);
    sample(V5);
    check_eq("ovf_flag", ov0, 1);
    check_eq("ovf_pass", p0, 4);
    check_eq("ovf_allpass", ap0, 0);

    // Same-address write during compare sees the old golden value.
    do_clear();
    step(1'b1, V5, 1'b1, 2'd0, VM1);
    check_eq("rbw_pass", p0, 1);
    check_eq("rbw_fail", f0, 0);
    sample(VM3);
    sample(V100);
    sample(V0);
    check_eq("rbw_total", p0, 4);

    // golden[0] is now 0xFFFFFF, compared against 0.
    do_clear();
    stream4(V0, VM3, V100, V0);
    check_eq("sgn_pass", p1, 4);
    check_eq("uns_fail", f2, 1);
    check_eq("uns_ffidx", fi2, 0);
    check_eq("uns_allpass", ap2, 0);
    check_eq("sgn_tol0_fail", f0, 1);

    // Reset mid-check acts immediately and discards the partial result.
    do_clear();
    sample(VM1);
    sample(VM3);
    check_eq("mid_pass", p0, 2);
    #2;
    rst_n = 1'b1;
    #1;
    check_eq("async_pass", p0, 0);
    check_eq("async_ffvld", fv2, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 2'd0, '0);
    stream4(VM1, VM3, V100, V0);
    check_eq("rerun_pass", p0, 4);
    check_eq("rerun_done", d0, 1);
    check_eq("rerun_allpass", ap0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_comparator.md
OUTPUT_COMPARATOR -- requirements
Module: output_comparator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: bit width of compared samples.
REQ-002 SHALL have parameter DEPTH, default 16: number of expected (golden) samples.
REQ-003 SHALL have parameter IS_SIGNED, default 1: 1 = two's-complement compare, 0 = unsigned.
REQ-004 SHALL have parameter TOLERANCE, default 0: maximum allowed |dut - golden| in LSBs.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-high reset (asserted = 1), named as in the codebase.
REQ-007 SHALL have port clear, input, 1 bit: synchronous restart of the check; golden memory is kept.
REQ-008 SHALL have port gold_wr_en, input, 1 bit: golden memory write strobe.
REQ-009 SHALL have port gold_wr_addr, input, clog2(DEPTH) bits: golden write address.
REQ-010 SHALL have port gold_wr_data, input, DATA_WIDTH bits: golden write data.
REQ-011 SHALL have port dut_ready, input, 1 bit: dut_output is valid this cycle.
REQ-012 SHALL have port dut_output, input, DATA_WIDTH bits: sample under test.
REQ-013 SHALL have port pass_cnt, output, clog2(DEPTH+1) bits: matching samples.
REQ-014 SHALL have port fail_cnt, output, clog2(DEPTH+1) bits: mismatching samples.
REQ-015 SHALL have port done, output, 1 bit: DEPTH samples compared.
REQ-016 SHALL have port all_pass, output, 1 bit: done, fail_cnt == 0 and overflow == 0.
REQ-017 SHALL have port first_fail_vld, output, 1 bit: a mismatch has been captured.
REQ-018 SHALL have port first_fail_idx, output, clog2(DEPTH) bits: index of the first mismatch.
REQ-019 SHALL have port overflow, output, 1 bit: dut_ready was seen after done.

Function
REQ-020 SHALL hold an internal sample pointer idx, starting at 0, that selects golden[idx].
REQ-021 SHALL, on a clk edge with dut_ready=1 and done=0, compute diff = |dut_output - golden[idx]| at DATA_WIDTH+1 bits, using the IS_SIGNED interpretation.
REQ-022 SHALL count the sample as a pass when diff <= TOLERANCE, otherwise as a fail.
REQ-023 SHALL increment pass_cnt or fail_cnt and idx in that same edge; the count is visible one cycle after the sample.
REQ-024 SHALL, on the first fail, latch first_fail_idx = idx and set first_fail_vld; both hold until reset or clear.
REQ-025 SHALL set done on the edge where idx reaches DEPTH (last sample compared); done holds.
REQ-026 SHALL ignore the sample when dut_ready=1 and done=1: counters are unchanged and overflow sets and holds.
REQ-027 SHALL write golden[gold_wr_addr] = gold_wr_data on a clk edge with gold_wr_en=1.
REQ-028 SHALL, when a write and a compare hit the same address in one cycle, compare against the old value (read-before-write).
REQ-029 SHALL, on clear=1, zero idx, both counters, done, overflow and first_fail_vld; clear takes priority over a simultaneous dut_ready.
REQ-030 SHALL drive all_pass combinationally from the registered flags.

Reset
REQ-031 SHALL, while rst_n=1, immediately force idx, pass_cnt, fail_cnt, first_fail_idx to 0 and done, overflow, first_fail_vld, all_pass to 0.
REQ-032 SHALL not reset golden memory contents.
REQ-033 SHALL, on reset asserted mid-check, discard the partial result; the check restarts from idx 0 after release.

Structure
REQ-034 SHALL take default widths and the TOLERANCE default from shared package comparator_pkg.
REQ-035 SHALL place the signed/unsigned absolute difference in one sub-module, output_comparator_absdiff (purely combinational).
REQ-036 SHALL implement golden memory as a register array with asynchronous read, so no read latency.

Verification
REQ-037 SHALL verify: DEPTH=4, TOL=0, golden {5,-3,100,0}, identical stream -> pass_cnt=4, fail_cnt=0, done=1, all_pass=1.
REQ-038 SHALL verify: same golden, stream {5,-2,100,0} -> fail_cnt=1, first_fail_idx=1, all_pass=0.
REQ-039 SHALL verify: TOL=1, stream {6,-4,99,1} -> pass_cnt=4; same stream with TOL=0 -> fail_cnt=4.
REQ-040 SHALL verify: 5 samples on DEPTH=4 -> overflow=1, counters stop at 4, all_pass=0.
REQ-041 SHALL verify: IS_SIGNED=0, golden 0xFFFFFF vs dut 0x000000, TOL=1 -> fail; the same pair with IS_SIGNED=1 -> pass.
REQ-042 SHALL verify: rst_n pulsed after 2 samples -> all outputs 0 asynchronously; rerun of 4 samples -> done=1, golden intact.
